// File: rtl/aidan_mcnay_piso_tx_pkg.sv
// Shared definitions for the PISO transmitter: FSM state encodings,
// bit-counter width helper and the frame-extension width used when the
// parity bit is built in (AIDAN_MCNAY_PISO_TX_PARITY_EN).
package aidan_mcnay_piso_tx_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_SEND = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Wide enough to hold nbits+1 (longest frame) without wrapping.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 2);
  endfunction

endpackage

// File: rtl/aidan_mcnay_down_counter.sv
// Loadable down-counter with an is-one flag; used as the frame bit counter.
// Ports: clk, reset (sync, active-high), load_i/load_val_i, dec_i, is_one_o.
// Decrement saturates at zero so the count never underflows.
module aidan_mcnay_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/aidan_mcnay_piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, feeding a SIPO receiver.
// Ports: clk, reset (sync, active-high), req_val/req_rdy/req_data request
// port, ser_en/ser_data serial link, done one-cycle end-of-frame pulse.
// Latency: first bit one cycle after handshake; done L+1 cycles after it.
// Optional even-parity trailer bit: define AIDAN_MCNAY_PISO_TX_PARITY_EN.
module aidan_mcnay_piso_tx
  import aidan_mcnay_piso_tx_pkg::*;
#(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [nbits-1:0] req_data,
  output logic             ser_en,
  output logic             ser_data,
  output logic             done
);

  localparam int CW        = cnt_width(nbits);
  localparam int FRAME_LEN = nbits + PARITY_BITS;

  logic [1:0]       state_q, state_d;
  logic [nbits-1:0] shreg_q, shreg_d;
  logic             cnt_load, cnt_dec, cnt_is_one;

  aidan_mcnay_down_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CW'(FRAME_LEN)),
    .dec_i      (cnt_dec),
    .is_one_o   (cnt_is_one)
  );

`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      STATE_IDLE: begin
        // req_rdy is high throughout IDLE, so req_val alone is the handshake.
        if (req_val) begin
          shreg_d  = req_data;
          cnt_load = 1'b1;
          state_d  = STATE_SEND;
`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
          parity_d = ^req_data;
`endif
        end
      end
      STATE_SEND: begin
        shreg_d = {shreg_q[nbits-2:0], 1'b0};
        cnt_dec = 1'b1;
        // Count of 1 means the last frame bit is on the wire this cycle.
        if (cnt_is_one) begin
          state_d = STATE_DONE;
        end
      end
      STATE_DONE: state_d = STATE_IDLE;
      default:    state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STATE_IDLE;
      shreg_q  <= '0;
`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // All outputs decode the state register only; nothing is combinational
  // from req_val.
  assign req_rdy = (state_q == STATE_IDLE);
  assign ser_en  = (state_q == STATE_SEND);
  assign done    = (state_q == STATE_DONE);

`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
  // The data bits occupy counts L..2; the trailer bit goes out at count 1.
  assign ser_data = ser_en & (cnt_is_one ? parity_q : shreg_q[nbits-1]);
`else
  assign ser_data = ser_en & shreg_q[nbits-1];
`endif

endmodule

// File: tb/tb_aidan_mcnay_piso_tx.sv
module tb_aidan_mcnay_piso_tx;

`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L16 = 16 + PB;
  localparam int L2  = 2 + PB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_val = 1'b0;
  logic [15:0] req_data = '0;
  logic        req_rdy, ser_en, ser_data, done;

  logic        req_val2 = 1'b0;
  logic [1:0]  req_data2 = '0;
  logic        req_rdy2, ser_en2, ser_data2, done2;

  logic [L16-1:0] sipo16;
  logic [L2-1:0]  sipo2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aidan_mcnay_piso_tx #(.nbits(16)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_data(req_data), .ser_en(ser_en), .ser_data(ser_data), .done(done)
  );

  aidan_mcnay_piso_tx #(.nbits(2)) dut2 (
    .clk(clk), .reset(reset), .req_val(req_val2), .req_rdy(req_rdy2),
    .req_data(req_data2), .ser_en(ser_en2), .ser_data(ser_data2), .done(done2)
  );

  // Loopback SIPO receivers.
  always @(posedge clk) begin
    if (reset) begin
      sipo16 <= '0;
      sipo2  <= '0;
    end else begin
      if (ser_en)  sipo16 <= {sipo16[L16-2:0], ser_data};
      if (ser_en2) sipo2  <= {sipo2[L2-2:0], ser_data2};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"},  32'(req_rdy),  32'd1);
    chk({tag, "_en"},   32'(ser_en),   32'd0);
    chk({tag, "_data"}, 32'(ser_data), 32'd0);
    chk({tag, "_done"}, 32'(done),     32'd0);
  endtask

  // Handshake w at the next edge (k), check all L bits, done at k+L+1 and
  // req_rdy at k+L+2. req_data is scrambled during SEND to prove immunity.
  task automatic xmit(input logic [15:0] w, input logic keep_val);
    logic [L16-1:0] exp_word;
`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
    exp_word = {w, ^w};
`else
    exp_word = w;
`endif
    req_val  = 1'b1;
    req_data = w;
    chk("hs_rdy", 32'(req_rdy), 32'd1);
    tick();
    if (!keep_val) req_val = 1'b0;
    req_data = ~w;
    for (int i = 0; i < L16; i++) begin
      if (i == 7) req_data = 16'h0000;
      chk("bit_en",   32'(ser_en),   32'd1);
      chk("bit_data", 32'(ser_data), 32'(exp_word[L16-1-i]));
      chk("bit_rdy",  32'(req_rdy),  32'd0);
      chk("bit_done", 32'(done),     32'd0);
      tick();
    end
    chk("done_pulse", 32'(done),   32'd1);
    chk("done_en",    32'(ser_en), 32'd0);
    chk("done_rdy",   32'(req_rdy), 32'd0);
    chk("sipo_word",  32'(sipo16), 32'(exp_word));
    tick();
    chk("rdy_back",  32'(req_rdy), 32'd1);
    chk("done_once", 32'(done),    32'd0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    // Reset state and three idle cycles.
    for (int i = 0; i < 3; i++) begin
      chk_idle("idle");
      tick();
    end

    // Single word.
    xmit(16'hA5C3, 1'b0);
    chk("sipo_a5c3", 32'(sipo16[15:0] >> 0), 32'(PB ? 16'h4B86 : 16'hA5C3));

    // Back-to-back with req_val held high: second handshake at k+L+2.
    xmit(16'hFFFF, 1'b1);
    xmit(16'h0001, 1'b0);
    chk_idle("after_b2b");

    // Reset in cycle k+5 of a 16'h1234 frame.
    req_val  = 1'b1;
    req_data = 16'h1234;
    tick();
    req_val = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_en", 32'(ser_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("abort");
      tick();
    end
    xmit(16'h00FF, 1'b0);

`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
    xmit(16'h0007, 1'b0);
    xmit(16'h0003, 1'b0);
`endif

    // nbits=2 instance: word 2'b10 -> bits 1, 0.
    chk("n2_rdy", 32'(req_rdy2), 32'd1);
    req_val2  = 1'b1;
    req_data2 = 2'b10;
    tick();
    req_val2  = 1'b0;
    req_data2 = 2'b01;
    chk("n2_b0_en", 32'(ser_en2),   32'd1);
    chk("n2_b0",    32'(ser_data2), 32'd1);
    tick();
    chk("n2_b1_en", 32'(ser_en2),   32'd1);
    chk("n2_b1",    32'(ser_data2), 32'd0);
    chk("n2_b1_dn", 32'(done2),     32'd0);
    tick();
`ifdef AIDAN_MCNAY_PISO_TX_PARITY_EN
    chk("n2_par",   32'(ser_data2), 32'd1);
    tick();
`endif
    chk("n2_done",  32'(done2),   32'd1);
    chk("n2_en",    32'(ser_en2), 32'd0);
    chk("n2_sipo",  32'(sipo2),   32'(PB ? 3'b101 : 3'b010));
    tick();
    chk("n2_rdy_back", 32'(req_rdy2), 32'd1);
    chk("n2_done_off", 32'(done2),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
